// File: rtl/csr_file_pkg.sv
// Shared definitions for the machine-mode CSR file:
// addresses, privilege levels, write masks and misa.
package csr_file_pkg;

   localparam logic [11:0] CSR_MSTATUS   = 12'h300;
   localparam logic [11:0] CSR_MISA      = 12'h301;
   localparam logic [11:0] CSR_MIE       = 12'h304;
   localparam logic [11:0] CSR_MTVEC     = 12'h305;
   localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
   localparam logic [11:0] CSR_MEPC      = 12'h341;
   localparam logic [11:0] CSR_MCAUSE    = 12'h342;
   localparam logic [11:0] CSR_MTVAL     = 12'h343;
   localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
   localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
   localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
   localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
   localparam logic [11:0] CSR_CYCLE     = 12'hC00;
   localparam logic [11:0] CSR_INSTRET   = 12'hC02;
   localparam logic [11:0] CSR_CYCLEH    = 12'hC80;
   localparam logic [11:0] CSR_INSTRETH  = 12'hC82;
   localparam logic [11:0] CSR_MHARTID   = 12'hF14;

   typedef enum logic [1:0] {
      USER       = 2'b00,
      SUPERVISOR = 2'b01,
      MACHINE    = 2'b11
   } priv_t;

   localparam logic [63:0] MSTATUS_MASK  = 64'h0000_1888;
   localparam logic [63:0] MIE_MASK      = 64'h0000_0888;
   localparam logic [63:0] MSTATUS_RESET = 64'h0000_1800;
   localparam logic [1:0]  MPP_RESERVED  = 2'b10;

   // MXL in the top two bits, extensions I (bit 8) and U (bit 20).
   function automatic logic [63:0] misa_value(input int xlen);
      logic [63:0] v;
      v = 64'h0000_0000_0010_0100;
      if (xlen == 64)
         v[63:62] = 2'd2;
      else
         v[31:30] = 2'd1;
      return v;
   endfunction

endpackage

// File: rtl/csr_file_counter64.sv
// 64-bit event counter with half-width loads;
// a load in the same cycle suppresses the increment.
module csr_counter64
   import csr_file_pkg::*;
#(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  inc,
   input  logic                  write_lo,
   input  logic                  write_hi,
   input  logic [DATA_WIDTH-1:0] wdata,
   output logic [63:0]           count
);

   logic [63:0] loaded;

   always_comb begin
      loaded = count;
      if (write_lo)
         loaded[DATA_WIDTH-1:0] = wdata;
      else if (write_hi)
         loaded[63:32] = wdata[31:0];
   end

   always_ff @(posedge clock) begin
      if (!reset)
         count <= '0;
      else if (write_lo || write_hi)
         count <= loaded;
      else if (inc)
         count <= count + 64'd1;
   end

endmodule

// File: rtl/csr_file.sv
// Machine-mode CSR file: combinational old-value read,
// clocked update, access checking and cycle/instret counters.
module csr_file
   import csr_file_pkg::*;
#(
   parameter int CORE       = 0,
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  CSR_read_en,
   input  logic                  CSR_write_en,
   input  logic                  CSR_set_en,
   input  logic                  CSR_clear_en,
   input  logic [11:0]           CSR_address,
   input  logic [DATA_WIDTH-1:0] CSR_write_data,
   input  logic [1:0]            current_privilege,
   input  logic                  instret_inc,
   output logic [DATA_WIDTH-1:0] CSR_read_data,
   output logic                  illegal_csr
);

   localparam int W = DATA_WIDTH;
   localparam bit HAS_HI = (DATA_WIDTH == 32);
   localparam logic [W-1:0] MISA_VAL   = W'(misa_value(DATA_WIDTH));
   localparam logic [W-1:0] HART_ID    = W'(CORE);
   localparam logic [W-1:0] MSTAT_WM   = W'(MSTATUS_MASK);
   localparam logic [W-1:0] MSTAT_RST  = W'(MSTATUS_RESET);
   localparam logic [W-1:0] MIE_WM     = W'(MIE_MASK);

   logic [W-1:0] mstatus;
   logic [W-1:0] mie;
   logic [W-1:0] mtvec;
   logic [W-1:0] mscratch;
   logic [W-1:0] mepc;
   logic [W-1:0] mcause;
   logic [W-1:0] mtval;
   logic [63:0]  mcycle;
   logic [63:0]  minstret;

   logic         modify;
   logic         any_en;
   logic         implemented;
   logic         priv_low;
   logic         read_only;
   logic         legal_mod;
   logic [W-1:0] old_val;
   logic [W-1:0] new_val;
   logic [W-1:0] mstatus_next;

   assign modify   = CSR_write_en | CSR_set_en | CSR_clear_en;
   assign any_en   = modify | CSR_read_en;
   assign priv_low = current_privilege < CSR_address[9:8];
   assign read_only = CSR_address[11:10] == 2'b11;

   always_comb begin
      implemented = 1'b1;
      old_val     = '0;
      case (CSR_address)
         CSR_MSTATUS:  old_val = mstatus;
         CSR_MISA:     old_val = MISA_VAL;
         CSR_MIE:      old_val = mie;
         CSR_MTVEC:    old_val = mtvec;
         CSR_MSCRATCH: old_val = mscratch;
         CSR_MEPC:     old_val = mepc;
         CSR_MCAUSE:   old_val = mcause;
         CSR_MTVAL:    old_val = mtval;
         CSR_MHARTID:  old_val = HART_ID;
         CSR_MCYCLE, CSR_CYCLE:
            old_val = mcycle[W-1:0];
         CSR_MINSTRET, CSR_INSTRET:
            old_val = minstret[W-1:0];
         CSR_MCYCLEH, CSR_CYCLEH: begin
            implemented = HAS_HI;
            old_val     = HAS_HI ? W'(mcycle[63:32]) : '0;
         end
         CSR_MINSTRETH, CSR_INSTRETH: begin
            implemented = HAS_HI;
            old_val     = HAS_HI ? W'(minstret[63:32]) : '0;
         end
         default: implemented = 1'b0;
      endcase
   end

   assign illegal_csr = any_en &
                        (~implemented | priv_low |
                         (modify & read_only));
   assign legal_mod   = modify & ~illegal_csr;

   assign CSR_read_data = (CSR_read_en && !illegal_csr) ?
                          old_val : '0;

   always_comb begin
      if (CSR_write_en)
         new_val = CSR_write_data;
      else if (CSR_set_en)
         new_val = old_val | CSR_write_data;
      else
         new_val = old_val & ~CSR_write_data;
   end

   // MPP=10 is reserved; such a write keeps the previous mode.
   always_comb begin
      mstatus_next = new_val & MSTAT_WM;
      if (mstatus_next[12:11] == MPP_RESERVED)
         mstatus_next[12:11] = mstatus[12:11];
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         mstatus  <= MSTAT_RST;
         mie      <= '0;
         mtvec    <= '0;
         mscratch <= '0;
         mepc     <= '0;
         mcause   <= '0;
         mtval    <= '0;
      end else if (legal_mod) begin
         case (CSR_address)
            CSR_MSTATUS:  mstatus  <= mstatus_next;
            CSR_MIE:      mie      <= new_val & MIE_WM;
            CSR_MTVEC:    mtvec    <= {new_val[W-1:2], 1'b0,
                                       new_val[0]};
            CSR_MSCRATCH: mscratch <= new_val;
            CSR_MEPC:     mepc     <= {new_val[W-1:2], 2'b00};
            CSR_MCAUSE:   mcause   <= new_val;
            CSR_MTVAL:    mtval    <= new_val;
            default: ;
         endcase
      end
   end

   csr_counter64 #(.DATA_WIDTH(W)) u_mcycle (
      .clock    (clock),
      .reset    (reset),
      .inc      (1'b1),
      .write_lo (legal_mod && CSR_address == CSR_MCYCLE),
      .write_hi (legal_mod && HAS_HI &&
                 CSR_address == CSR_MCYCLEH),
      .wdata    (new_val),
      .count    (mcycle)
   );

   csr_counter64 #(.DATA_WIDTH(W)) u_minstret (
      .clock    (clock),
      .reset    (reset),
      .inc      (instret_inc),
      .write_lo (legal_mod && CSR_address == CSR_MINSTRET),
      .write_hi (legal_mod && HAS_HI &&
                 CSR_address == CSR_MINSTRETH),
      .wdata    (new_val),
      .count    (minstret)
   );

endmodule

// File: tb/tb_csr_file.sv
// Directed bench for csr_file (RV32, hart id 5):
// reads, modifies, access faults, counters and reset.
module tb_csr_file;
   import csr_file_pkg::*;

   logic        clock = 1'b0;
   logic        reset;
   logic        rd_en, wr_en, st_en, cl_en;
   logic [11:0] addr;
   logic [31:0] wdata;
   logic [1:0]  priv;
   logic        inc;
   logic [31:0] rdata;
   logic        illegal;

   int checks = 0;
   int errors = 0;

   csr_file #(.CORE(5), .DATA_WIDTH(32)) dut (
      .clock             (clock),
      .reset             (reset),
      .CSR_read_en       (rd_en),
      .CSR_write_en      (wr_en),
      .CSR_set_en        (st_en),
      .CSR_clear_en      (cl_en),
      .CSR_address       (addr),
      .CSR_write_data    (wdata),
      .current_privilege (priv),
      .instret_inc       (inc),
      .CSR_read_data     (rdata),
      .illegal_csr       (illegal)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic r, input logic w,
                        input logic s, input logic c,
                        input logic [11:0] a, input logic [31:0] d,
                        input logic [1:0] p, input logic i);
      rd_en = r;
      wr_en = w;
      st_en = s;
      cl_en = c;
      addr  = a;
      wdata = d;
      priv  = p;
      inc   = i;
   endtask

   // Apply one access at the falling edge; outputs settle by +1.
   task automatic op(input logic r, input logic w,
                     input logic s, input logic c,
                     input logic [11:0] a, input logic [31:0] d,
                     input logic [1:0] p, input logic i);
      @(negedge clock);
      drive(r, w, s, c, a, d, p, i);
      #1;
   endtask

   task automatic rd(input logic [11:0] a);
      op(1, 0, 0, 0, a, 32'h0, MACHINE, 0);
   endtask

   initial begin
      reset = 1'b0;
      drive(0, 0, 0, 0, 12'h0, 32'h0, MACHINE, 0);
      repeat (2) @(posedge clock);

      rd(CSR_MSTATUS);
      chk("rst_mstatus", rdata, 32'h0000_1800);
      chk("rst_illegal", {31'b0, illegal}, 32'h0);

      @(negedge clock);
      reset = 1'b1;
      drive(0, 0, 0, 0, 12'h0, 32'h0, MACHINE, 0);
      repeat (2) @(negedge clock);

      rd(CSR_MCYCLE);
      chk("mcycle_after_rst", rdata, 32'd3);
      rd(CSR_MCYCLEH);
      chk("mcycleh_after_rst", rdata, 32'd0);
      rd(CSR_MISA);
      chk("misa", rdata, 32'h4010_0100);
      rd(CSR_MHARTID);
      chk("mhartid", rdata, 32'd5);

      op(1, 1, 0, 0, CSR_MSCRATCH, 32'hDEAD_BEEF, MACHINE, 0);
      chk("csrrw_old", rdata, 32'h0);
      chk("csrrw_legal", {31'b0, illegal}, 32'h0);
      rd(CSR_MSCRATCH);
      chk("mscratch_new", rdata, 32'hDEAD_BEEF);

      op(1, 0, 1, 0, CSR_MSTATUS, 32'h8, MACHINE, 0);
      chk("csrrs_old", rdata, 32'h0000_1800);
      op(1, 0, 0, 1, CSR_MSTATUS, 32'h8, MACHINE, 0);
      chk("csrrc_old", rdata, 32'h0000_1808);
      op(1, 1, 0, 0, CSR_MSTATUS, 32'h1000, MACHINE, 0);
      chk("mie_cleared", rdata, 32'h0000_1800);
      rd(CSR_MSTATUS);
      chk("mpp_reserved_kept", rdata, 32'h0000_1800);
      op(0, 1, 0, 0, CSR_MSTATUS, 32'h0, MACHINE, 0);
      rd(CSR_MSTATUS);
      chk("mpp_user", rdata, 32'h0);
      op(0, 1, 0, 0, CSR_MSTATUS, 32'hFFFF_FFFF, MACHINE, 0);
      rd(CSR_MSTATUS);
      chk("mstatus_mask", rdata, 32'h0000_1888);

      op(0, 1, 0, 0, CSR_MTVEC, 32'hFFFF_FFFF, MACHINE, 0);
      rd(CSR_MTVEC);
      chk("mtvec_bit1", rdata, 32'hFFFF_FFFD);
      op(0, 1, 0, 0, CSR_MEPC, 32'hFFFF_FFFF, MACHINE, 0);
      rd(CSR_MEPC);
      chk("mepc_align", rdata, 32'hFFFF_FFFC);
      op(0, 1, 0, 0, CSR_MIE, 32'hFFFF_FFFF, MACHINE, 0);
      rd(CSR_MIE);
      chk("mie_mask", rdata, 32'h0000_0888);

      op(1, 1, 0, 1, CSR_MSCRATCH, 32'h0000_FFFF, MACHINE, 0);
      chk("prio_old", rdata, 32'hDEAD_BEEF);
      rd(CSR_MSCRATCH);
      chk("write_over_clear", rdata, 32'h0000_FFFF);
      op(0, 0, 1, 1, CSR_MSCRATCH, 32'hF000_0000, MACHINE, 0);
      rd(CSR_MSCRATCH);
      chk("set_over_clear", rdata, 32'hF000_FFFF);

      op(0, 1, 0, 0, CSR_MCYCLE, 32'd100, MACHINE, 0);
      op(1, 1, 0, 0, CSR_CYCLE, 32'h0, MACHINE, 0);
      chk("cycle_wr_illegal", {31'b0, illegal}, 32'h1);
      chk("cycle_wr_rdata", rdata, 32'h0);
      rd(CSR_MCYCLE);
      chk("mcycle_keeps_counting", rdata, 32'd101);

      op(1, 0, 0, 0, CSR_MSCRATCH, 32'h0, USER, 0);
      chk("u_read_illegal", {31'b0, illegal}, 32'h1);
      chk("u_read_rdata", rdata, 32'h0);
      op(0, 1, 0, 0, CSR_MSCRATCH, 32'h1234, USER, 0);
      chk("u_write_illegal", {31'b0, illegal}, 32'h1);
      rd(CSR_MSCRATCH);
      chk("u_write_no_effect", rdata, 32'hF000_FFFF);
      op(1, 0, 0, 0, CSR_MSTATUS, 32'h0, SUPERVISOR, 0);
      chk("s_read_illegal", {31'b0, illegal}, 32'h1);
      op(1, 0, 0, 0, CSR_CYCLE, 32'h0, USER, 0);
      chk("u_cycle_legal", {31'b0, illegal}, 32'h0);
      rd(12'h7C0);
      chk("unimpl_illegal", {31'b0, illegal}, 32'h1);
      op(0, 1, 0, 0, CSR_MHARTID, 32'h1, MACHINE, 0);
      chk("mhartid_wr_illegal", {31'b0, illegal}, 32'h1);

      op(0, 1, 0, 0, CSR_MCYCLE, 32'hFFFF_FFFF, MACHINE, 0);
      op(0, 1, 0, 0, CSR_MCYCLEH, 32'h0, MACHINE, 0);
      rd(CSR_MCYCLEH);
      chk("mcycleh_written", rdata, 32'h0);
      rd(CSR_MCYCLEH);
      chk("mcycleh_carry", rdata, 32'h1);
      rd(CSR_MCYCLE);
      chk("mcycle_wrapped", rdata, 32'h1);

      repeat (5) op(0, 0, 0, 0, 12'h0, 32'h0, MACHINE, 1);
      rd(CSR_MINSTRET);
      chk("minstret_5", rdata, 32'd5);
      rd(CSR_INSTRET);
      chk("instret_alias", rdata, 32'd5);
      op(1, 1, 0, 0, CSR_MINSTRET, 32'd7, MACHINE, 1);
      chk("minstret_old", rdata, 32'd5);
      rd(CSR_MINSTRET);
      chk("minstret_write_wins", rdata, 32'd7);
      op(0, 1, 0, 0, CSR_INSTRET, 32'h0, MACHINE, 1);
      chk("instret_wr_illegal", {31'b0, illegal}, 32'h1);
      rd(CSR_MINSTRET);
      chk("minstret_still_incs", rdata, 32'd8);
      rd(CSR_MINSTRETH);
      chk("minstreth", rdata, 32'd0);

      @(negedge clock);
      reset = 1'b0;
      drive(0, 1, 0, 0, CSR_MSCRATCH, 32'h55, MACHINE, 1);
      @(negedge clock);
      reset = 1'b1;
      drive(1, 0, 0, 0, CSR_MCYCLE, 32'h0, MACHINE, 0);
      #1;
      chk("mid_rst_mcycle", rdata, 32'd0);
      rd(CSR_MINSTRET);
      chk("mid_rst_minstret", rdata, 32'd0);
      rd(CSR_MSCRATCH);
      chk("mid_rst_mscratch", rdata, 32'd0);
      rd(CSR_MSTATUS);
      chk("mid_rst_mstatus", rdata, 32'h0000_1800);
      rd(CSR_MIE);
      chk("mid_rst_mie", rdata, 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
